// File: rtl/change_dispenser_if.sv
// Handshake bundle between the transaction FSM / coin ejector (master side)
// and the change dispenser (slave side).
interface change_dispenser_if;
    logic       start;
    logic [7:0] change_money;
    logic [4:0] stock_empty;
    logic       coin_ack;
    logic       coin_req;
    logic [4:0] coin_sel;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;
    logic [7:0] coin_count;

    modport master (
        output start, change_money, stock_empty, coin_ack,
        input  coin_req, coin_sel, busy, done, error, remaining, coin_count
    );

    modport slave (
        input  start, change_money, stock_empty, coin_ack,
        output coin_req, coin_sel, busy, done, error, remaining, coin_count
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-by-coin change payout (50/20/10/5/1) with a req/ack handshake
// to the ejector, inter-coin gap and per-coin ack timeout.
module change_dispenser #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    change_dispenser_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SELECT, REQ, GAP, DONE, ERR} state_e;

    state_e          state_q, state_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [7:0]      count_q, count_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      sel_q, sel_d;
    logic            req_q, req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [4:0]      pick_sel;

    function automatic logic [7:0] coin_val(input logic [4:0] s);
        if (s[4])      return 8'd50;
        else if (s[3]) return 8'd20;
        else if (s[2]) return 8'd10;
        else if (s[1]) return 8'd5;
        else if (s[0]) return 8'd1;
        else           return 8'd0;
    endfunction

    // Largest in-stock denomination not exceeding what is still owed.
    always_comb begin
        pick_sel = '0;
        if (remaining_q >= 8'd50 && !bus.stock_empty[4])      pick_sel = 5'b10000;
        else if (remaining_q >= 8'd20 && !bus.stock_empty[3]) pick_sel = 5'b01000;
        else if (remaining_q >= 8'd10 && !bus.stock_empty[2]) pick_sel = 5'b00100;
        else if (remaining_q >= 8'd5  && !bus.stock_empty[1]) pick_sel = 5'b00010;
        else if (remaining_q >= 8'd1  && !bus.stock_empty[0]) pick_sel = 5'b00001;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SELECT;
            SELECT:  if (remaining_q == 8'd0) state_d = DONE;
                     else if (pick_sel != '0) state_d = REQ;
                     else                     state_d = ERR;
            REQ:     if (bus.coin_ack)                            state_d = GAP;
                     else if (cnt_q == CW'(TIMEOUT_CYCLES - 1))  state_d = ERR;
            GAP:     if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = SELECT;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        remaining_d = remaining_q;
        count_d     = count_q;
        cnt_d       = '0;
        sel_d       = '0;
        if (state_q == IDLE && bus.start) begin
            remaining_d = bus.change_money;
            count_d     = '0;
        end
        if (state_q == REQ && bus.coin_ack) begin
            remaining_d = remaining_q - coin_val(sel_q);
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
        if (state_d == state_q && (state_q == REQ || state_q == GAP))
            cnt_d = cnt_q + 1'b1;
        if (state_d == REQ)
            sel_d = (state_q == SELECT) ? pick_sel : sel_q;
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            remaining_q <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            sel_q       <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.coin_req   = req_q;
    assign bus.coin_sel   = sel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;
    assign bus.remaining  = remaining_q;
    assign bus.coin_count = count_q;
endmodule
